// File: rtl/exc_sequencer.sv
`timescale 1ns/1ps
// exc_sequencer
// Commit-point controller between the M-stage pipeline register and CP0.
// Arbitrates synchronous exceptions, ERET and interrupts (exception > ERET >
// interrupt), issues one isException strobe to CP0 per event, then sequences
// flush, stall and a PC redirect to the CP0-supplied handler/EPC address.
//
// Ports:
//   clk, reset (async, active-low)
//   memValid, pipeExcValid, pipeExcCause, pipeEret, memPC, memBD,
//   memBadVAddr, stageExcPending          : M-stage / pipeline event inputs
//   interruptNow, cp0Jump, cp0JumpAddress : from CP0
//   cp0IsException, cp0Cause, cp0PC, cp0BadVAddr, cp0IsBD : to CP0
//   hasExceptionInPipeline                : to CP0 interrupt masking
//   flush, stall, redirect, redirectPC    : pipeline control
//   busy                                  : sequencer not idle
//   fault                                 : sticky, CP0 did not jump on ISSUE
//
// Optional build macro EXC_SEQ_COUNT_EN adds saturating 16-bit event
// counters excCount, eretCount and intCount.
module exc_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [4:0]  CAUSE_INT    = 5'd0,
  parameter logic [4:0]  CAUSE_ERET   = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memValid,
  input  logic        pipeExcValid,
  input  logic [4:0]  pipeExcCause,
  input  logic        pipeEret,
  input  logic [31:0] memPC,
  input  logic        memBD,
  input  logic [31:0] memBadVAddr,
  input  logic [2:0]  stageExcPending,
  input  logic        interruptNow,
  input  logic        cp0Jump,
  input  logic [31:0] cp0JumpAddress,
  output logic        cp0IsException,
  output logic [4:0]  cp0Cause,
  output logic [31:0] cp0PC,
  output logic [31:0] cp0BadVAddr,
  output logic        cp0IsBD,
  output logic        hasExceptionInPipeline,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPC,
  output logic        busy,
`ifdef EXC_SEQ_COUNT_EN
  output logic [15:0] excCount,
  output logic [15:0] eretCount,
  output logic [15:0] intCount,
`endif
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_REDIRECT
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_exc_q, is_exc_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] bva_q, bva_d;
  logic        bd_q, bd_d;
  logic        flush_q, flush_d;
  logic        stall_q, stall_d;
  logic        redirect_q, redirect_d;
  logic [31:0] rpc_q, rpc_d;
  logic        fault_q, fault_d;

  logic        take_event;

`ifdef EXC_SEQ_COUNT_EN
  logic [15:0] exc_cnt_q, exc_cnt_d;
  logic [15:0] eret_cnt_q, eret_cnt_d;
  logic [15:0] int_cnt_q, int_cnt_d;
`endif

  assign take_event = memValid & (pipeExcValid | pipeEret | interruptNow);

  // Outputs are registered: each state's outputs are computed on the
  // transition into that state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_exc_d   = 1'b0;
    cause_d    = cause_q;
    pc_d       = pc_q;
    bva_d      = bva_q;
    bd_d       = bd_q;
    flush_d    = 1'b0;
    stall_d    = 1'b0;
    redirect_d = 1'b0;
    rpc_d      = rpc_q;
    fault_d    = fault_q;
`ifdef EXC_SEQ_COUNT_EN
    exc_cnt_d  = exc_cnt_q;
    eret_cnt_d = eret_cnt_q;
    int_cnt_d  = int_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (take_event) begin
          state_d  = S_ISSUE;
          is_exc_d = 1'b1;
          flush_d  = 1'b1;
          stall_d  = 1'b1;
          pc_d     = memPC;
          bd_d     = memBD;
          bva_d    = memBadVAddr;
          if (pipeExcValid) begin
            cause_d = pipeExcCause;
`ifdef EXC_SEQ_COUNT_EN
            if (exc_cnt_q != '1) exc_cnt_d = exc_cnt_q + 16'd1;
`endif
          end else if (pipeEret) begin
            cause_d = CAUSE_ERET;
`ifdef EXC_SEQ_COUNT_EN
            if (eret_cnt_q != '1) eret_cnt_d = eret_cnt_q + 16'd1;
`endif
          end else begin
            cause_d = CAUSE_INT;
`ifdef EXC_SEQ_COUNT_EN
            if (int_cnt_q != '1) int_cnt_d = int_cnt_q + 16'd1;
`endif
          end
        end
      end

      S_ISSUE: begin
        // CP0 derives jump/address combinationally from isException,
        // so they are valid during this cycle only.
        rpc_d   = cp0JumpAddress;
        if (!cp0Jump) fault_d = 1'b1;
        cnt_d   = CNT_INIT;
        state_d = S_FLUSH;
        flush_d = 1'b1;
        stall_d = 1'b1;
      end

      S_FLUSH: begin
        if (cnt_q == '0) begin
          state_d    = S_REDIRECT;
          redirect_d = 1'b1;
          stall_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end

      S_REDIRECT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_exc_q   <= 1'b0;
      cause_q    <= '0;
      pc_q       <= '0;
      bva_q      <= '0;
      bd_q       <= 1'b0;
      flush_q    <= 1'b0;
      stall_q    <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      fault_q    <= 1'b0;
`ifdef EXC_SEQ_COUNT_EN
      exc_cnt_q  <= '0;
      eret_cnt_q <= '0;
      int_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_exc_q   <= is_exc_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      bva_q      <= bva_d;
      bd_q       <= bd_d;
      flush_q    <= flush_d;
      stall_q    <= stall_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      fault_q    <= fault_d;
`ifdef EXC_SEQ_COUNT_EN
      exc_cnt_q  <= exc_cnt_d;
      eret_cnt_q <= eret_cnt_d;
      int_cnt_q  <= int_cnt_d;
`endif
    end
  end

  assign busy                   = (state_q != S_IDLE);
  assign hasExceptionInPipeline = (|stageExcPending) | pipeExcValid | pipeEret | busy;

  assign cp0IsException = is_exc_q;
  assign cp0Cause       = cause_q;
  assign cp0PC          = pc_q;
  assign cp0BadVAddr    = bva_q;
  assign cp0IsBD        = bd_q;
  assign flush          = flush_q;
  assign stall          = stall_q;
  assign redirect       = redirect_q;
  assign redirectPC     = rpc_q;
  assign fault          = fault_q;

`ifdef EXC_SEQ_COUNT_EN
  assign excCount  = exc_cnt_q;
  assign eretCount = eret_cnt_q;
  assign intCount  = int_cnt_q;
`endif

endmodule

// File: tb/tb_exc_sequencer.sv
`timescale 1ns/1ps
// tb_exc_sequencer
// Self-checking bench for exc_sequencer: directed scenarios followed by
// randomized traffic, compared against a cycle-count reference model.
module tb_exc_sequencer;

  localparam int FC = 2;

  logic        clk;
  logic        reset;
  logic        memValid;
  logic        pipeExcValid;
  logic [4:0]  pipeExcCause;
  logic        pipeEret;
  logic [31:0] memPC;
  logic        memBD;
  logic [31:0] memBadVAddr;
  logic [2:0]  stageExcPending;
  logic        interruptNow;
  logic        cp0Jump;
  logic [31:0] cp0JumpAddress;
  logic        cp0IsException;
  logic [4:0]  cp0Cause;
  logic [31:0] cp0PC;
  logic [31:0] cp0BadVAddr;
  logic        cp0IsBD;
  logic        hasExceptionInPipeline;
  logic        flush;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        busy;
  logic        fault;
`ifdef EXC_SEQ_COUNT_EN
  logic [15:0] excCount, eretCount, intCount;
`endif

  exc_sequencer #(
    .FLUSH_CYCLES(FC),
    .CAUSE_INT(5'd0),
    .CAUSE_ERET(5'd31)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memValid(memValid),
    .pipeExcValid(pipeExcValid),
    .pipeExcCause(pipeExcCause),
    .pipeEret(pipeEret),
    .memPC(memPC),
    .memBD(memBD),
    .memBadVAddr(memBadVAddr),
    .stageExcPending(stageExcPending),
    .interruptNow(interruptNow),
    .cp0Jump(cp0Jump),
    .cp0JumpAddress(cp0JumpAddress),
    .cp0IsException(cp0IsException),
    .cp0Cause(cp0Cause),
    .cp0PC(cp0PC),
    .cp0BadVAddr(cp0BadVAddr),
    .cp0IsBD(cp0IsBD),
    .hasExceptionInPipeline(hasExceptionInPipeline),
    .flush(flush),
    .stall(stall),
    .redirect(redirect),
    .redirectPC(redirectPC),
    .busy(busy),
`ifdef EXC_SEQ_COUNT_EN
    .excCount(excCount),
    .eretCount(eretCount),
    .intCount(intCount),
`endif
    .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: k = cycles elapsed since the accepted event (0 = idle).
  int          k;
  logic [4:0]  m_cause;
  logic [31:0] m_pc, m_bva, m_rpc;
  logic        m_bd, m_fault;
  int          m_exc_n, m_eret_n, m_int_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_cause = '0; m_pc = '0; m_bva = '0; m_rpc = '0;
    m_bd = 1'b0; m_fault = 1'b0;
    m_exc_n = 0; m_eret_n = 0; m_int_n = 0;
  endtask

  // Advance the model across one rising edge using the inputs present now.
  task automatic model_edge();
    if (k == 0) begin
      if (memValid && (pipeExcValid || pipeEret || interruptNow)) begin
        if (pipeExcValid) begin m_cause = pipeExcCause; m_exc_n++; end
        else if (pipeEret) begin m_cause = 5'd31; m_eret_n++; end
        else begin m_cause = 5'd0; m_int_n++; end
        m_pc = memPC; m_bd = memBD; m_bva = memBadVAddr;
        k = 1;
      end
    end else if (k == 1) begin
      m_rpc = cp0JumpAddress;
      if (!cp0Jump) m_fault = 1'b1;
      k = 2;
    end else if (k == FC + 2) begin
      k = 0;
    end else begin
      k++;
    end
  endtask

  task automatic compare_all();
    check_eq("busy",       32'(busy),           32'(k != 0));
    check_eq("isExc",      32'(cp0IsException), 32'(k == 1));
    check_eq("flush",      32'(flush),          32'(k >= 1 && k <= FC + 1));
    check_eq("stall",      32'(stall),          32'(k >= 1 && k <= FC + 2));
    check_eq("redirect",   32'(redirect),       32'(k == FC + 2));
    check_eq("cause",      32'(cp0Cause),       32'(m_cause));
    check_eq("cp0PC",      cp0PC,               m_pc);
    check_eq("badVAddr",   cp0BadVAddr,         m_bva);
    check_eq("isBD",       32'(cp0IsBD),        32'(m_bd));
    check_eq("redirectPC", redirectPC,          m_rpc);
    check_eq("fault",      32'(fault),          32'(m_fault));
`ifdef EXC_SEQ_COUNT_EN
    check_eq("excCount",  32'(excCount),  32'(m_exc_n));
    check_eq("eretCount", 32'(eretCount), 32'(m_eret_n));
    check_eq("intCount",  32'(intCount),  32'(m_int_n));
`endif
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    #1;
    check_eq("hasExcInPipe", 32'(hasExceptionInPipeline),
             32'((|stageExcPending) | pipeExcValid | pipeEret | (k != 0)));
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    memValid = 1'b0; pipeExcValid = 1'b0; pipeExcCause = '0; pipeEret = 1'b0;
    memPC = '0; memBD = 1'b0; memBadVAddr = '0; stageExcPending = '0;
    interruptNow = 1'b0; cp0Jump = 1'b1; cp0JumpAddress = '0;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop at once.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_isExc",    32'(cp0IsException), 32'd0);
    check_eq("rst_flush",    32'(flush),          32'd0);
    check_eq("rst_stall",    32'(stall),          32'd0);
    check_eq("rst_redirect", 32'(redirect),       32'd0);
    check_eq("rst_busy",     32'(busy),           32'd0);
    check_eq("rst_fault",    32'(fault),          32'd0);
    check_eq("rst_rpc",      redirectPC,          32'd0);
    check_eq("rst_cause",    32'(cp0Cause),       32'd0);
    model_reset();
    @(negedge clk);
    check_eq("rst_hold_redirect", 32'(redirect), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // Exception, with a second exception raised while busy.
    memValid = 1'b1; pipeExcValid = 1'b1; pipeExcCause = 5'd4;
    memPC = 32'h0000_3010; memBD = 1'b0; memBadVAddr = 32'h0000_0BAD;
    cp0Jump = 1'b1; cp0JumpAddress = 32'hBFC0_0380;
    step();
    check_eq("exc_cause", 32'(cp0Cause), 32'd4);
    check_eq("exc_pc",    cp0PC,         32'h0000_3010);
    pipeExcCause = 5'd7; memPC = 32'h0000_3014;
    step();
    step();
    pipeExcValid = 1'b0;
    step();
    check_eq("exc_redirectPC", redirectPC, 32'hBFC0_0380);
    step();
    check_eq("exc_idle", 32'(busy), 32'd0);

    // ERET.
    clear_inputs();
    memValid = 1'b1; pipeEret = 1'b1; memPC = 32'h0000_4000;
    cp0JumpAddress = 32'h0000_3014;
    step();
    pipeEret = 1'b0;
    repeat (FC + 2) step();
    check_eq("eret_cause", 32'(cp0Cause), 32'd31);
    check_eq("eret_rpc",   redirectPC,    32'h0000_3014);
    check_eq("eret_fault", 32'(fault),    32'd0);

    // Priority: all three sources at once.
    clear_inputs();
    memValid = 1'b1; pipeExcValid = 1'b1; pipeExcCause = 5'd12; pipeEret = 1'b1;
    interruptNow = 1'b1; memPC = 32'h0000_5000; cp0JumpAddress = 32'hBFC0_0380;
    step();
    check_eq("prio_cause", 32'(cp0Cause), 32'd12);
    clear_inputs();
    repeat (FC + 2) step();
    // Interrupt pending with a bubble in M: must wait.
    interruptNow = 1'b1; memPC = 32'h0000_6000;
    repeat (3) step();
    check_eq("int_wait", 32'(busy), 32'd0);
    memValid = 1'b1;
    step();
    check_eq("int_cause", 32'(cp0Cause), 32'd0);
    clear_inputs();
    repeat (FC + 2) step();

    // Masking from earlier stages while idle.
    stageExcPending = 3'b010;
    step();
    check_eq("mask_hasExc", 32'(hasExceptionInPipeline), 32'd1);
    check_eq("mask_busy",   32'(busy),                   32'd0);
    clear_inputs();

    // CP0 fails to jump: sticky fault.
    memValid = 1'b1; pipeExcValid = 1'b1; pipeExcCause = 5'd10; memBD = 1'b1;
    step();
    clear_inputs();
    cp0Jump = 1'b0; cp0JumpAddress = 32'h1234_5678;
    step();
    cp0Jump = 1'b1;
    repeat (FC + 6) step();
    check_eq("fault_sticky", 32'(fault), 32'd1);

    // Reset in the middle of FLUSH.
    memValid = 1'b1; interruptNow = 1'b1;
    step();
    clear_inputs();
    step();
    step();
    check_eq("pre_rst_flush", 32'(flush), 32'd1);
    async_reset();
    step();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      memValid        = ($urandom_range(0, 3) != 0);
      pipeExcValid    = ($urandom_range(0, 4) == 0);
      pipeExcCause    = 5'($urandom);
      pipeEret        = ($urandom_range(0, 5) == 0);
      memPC           = $urandom;
      memBD           = 1'($urandom);
      memBadVAddr     = $urandom;
      stageExcPending = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      interruptNow    = ($urandom_range(0, 4) == 0);
      cp0Jump         = ($urandom_range(0, 15) != 0);
      cp0JumpAddress  = $urandom;
      if ($urandom_range(0, 399) == 0) async_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
